// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game control path.
// Holds the FSM state encoding, the LED mode codes, the address-mux select
// codes and the default pattern-memory depth. Helper functions map a state
// to its select and LED codes so every consumer decodes states the same way.
package simon_pkg;

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [2:0] LED_INPUT    = 3'b001;
  localparam logic [2:0] LED_PLAYBACK = 3'b010;
  localparam logic [2:0] LED_REPEAT   = 3'b100;
  localparam logic [2:0] LED_DONE     = 3'b111;

  localparam logic [1:0] SEL_COUNT    = 2'b00;
  localparam logic [1:0] SEL_PLAYBACK = 2'b01;
  localparam logic [1:0] SEL_REPEAT   = 2'b10;
  localparam logic [1:0] SEL_DONE     = 2'b11;

  localparam int MAX_LEN_DEF = 64;

  function automatic logic [2:0] led_of(input state_t s);
    case (s)
      ST_INPUT:    return LED_INPUT;
      ST_PLAYBACK: return LED_PLAYBACK;
      ST_REPEAT:   return LED_REPEAT;
      default:     return LED_DONE;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      ST_INPUT:    return SEL_COUNT;
      ST_PLAYBACK: return SEL_PLAYBACK;
      ST_REPEAT:   return SEL_REPEAT;
      default:     return SEL_DONE;
    endcase
  endfunction

endpackage

// File: rtl/simon_btn_sync.sv
// Push-button front end: two-flop synchroniser followed by a registered
// rising-edge detector. A held button yields exactly one o_pulse, which
// appears three clock edges after the raw input rises.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_btn    raw button, asynchronous to i_clk
//   o_pulse  one-cycle press pulse
module simon_btn_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_s1, r_s2, r_s3, r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_pulse <= r_s2 & ~r_s3;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/simon_sequencer.sv
// Control FSM for the Simon datapath: pattern entry, timed playback,
// player repeat and game-over display. All outputs are registered; select
// and mode_leds are decoded from the next state so they change on the same
// edge as the state itself.
// Optional macro SIMON_TIMEOUT_EN: adds a REPEAT inactivity timeout that
// ends the game after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   step                raw submit button
//   is_legal, play_end, repeat_end, input_match   datapath status
//   select              address mux select (00 count,01 play,10 rep,11 done)
//   mode_leds           001 INPUT, 010 PLAYBACK, 100 REPEAT, 111 DONE
//   w_en                pattern memory write strobe
//   adv / clr_idx       index increment / index clear pulses
//   len                 number of stored entries
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int STEP_CYCLES    = 4,
  parameter int MAX_LEN        = MAX_LEN_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       is_legal,
  input  logic       play_end,
  input  logic       repeat_end,
  input  logic       input_match,
  output logic [1:0] select,
  output logic [2:0] mode_leds,
  output logic       w_en,
  output logic       adv,
  output logic       clr_idx,
  output logic [6:0] len
);

  // One counter serves both the display timer and the REPEAT idle timer,
  // so size it for whichever limit is larger.
  localparam int T_MAX = (STEP_CYCLES > TIMEOUT_CYCLES) ? STEP_CYCLES : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);

  state_t        r_state, w_nstate;
  logic [TW-1:0] r_timer, w_ntimer;
  logic [6:0]    r_len, w_nlen;
  logic [1:0]    r_sel;
  logic [2:0]    r_led;
  logic          r_wen, r_adv, r_clr;
  logic          w_nwen, w_nadv, w_nclr;
  logic          w_press, w_tc, w_full;

  simon_btn_sync u_step_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_btn   (step),
    .o_pulse (w_press)
  );

  assign w_tc   = (r_timer == TW'(STEP_CYCLES - 1));
  assign w_full = (r_len == 7'(MAX_LEN));

  always_comb begin
    w_nstate = r_state;
    w_ntimer = r_timer;
    w_nlen   = r_len;
    w_nwen   = 1'b0;
    w_nadv   = 1'b0;
    w_nclr   = 1'b0;
    case (r_state)
      ST_INPUT: begin
        w_ntimer = '0;
        if (w_press) begin
          // A full memory still starts playback; there is just nothing to store.
          if (w_full) begin
            w_nclr   = 1'b1;
            w_nstate = ST_PLAYBACK;
          end else if (is_legal) begin
            w_nwen   = 1'b1;
            w_nlen   = r_len + 7'd1;
            w_nclr   = 1'b1;
            w_nstate = ST_PLAYBACK;
          end
        end
      end
      ST_PLAYBACK: begin
        if (w_tc) begin
          w_ntimer = '0;
          if (play_end) begin
            w_nclr   = 1'b1;
            w_nstate = ST_REPEAT;
          end else begin
            w_nadv = 1'b1;
          end
        end else begin
          w_ntimer = r_timer + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (w_press) begin
          w_ntimer = '0;
          if (!input_match) begin
            w_nclr   = 1'b1;
            w_nstate = ST_DONE;
          end else if (repeat_end) begin
            w_nclr   = 1'b1;
            w_nstate = ST_INPUT;
          end else begin
            w_nadv = 1'b1;
          end
        end else begin
`ifdef SIMON_TIMEOUT_EN
          if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            w_ntimer = '0;
            w_nclr   = 1'b1;
            w_nstate = ST_DONE;
          end else begin
            w_ntimer = r_timer + 1'b1;
          end
`else
          w_ntimer = '0;
`endif
        end
      end
      default: begin // ST_DONE: endless replay, wrapping at the last entry
        if (w_tc) begin
          w_ntimer = '0;
          if (play_end) w_nclr = 1'b1;
          else          w_nadv = 1'b1;
        end else begin
          w_ntimer = r_timer + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INPUT;
      r_timer <= '0;
      r_len   <= '0;
      r_sel   <= SEL_COUNT;
      r_led   <= LED_INPUT;
      r_wen   <= 1'b0;
      r_adv   <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_timer <= w_ntimer;
      r_len   <= w_nlen;
      r_sel   <= sel_of(w_nstate);
      r_led   <= led_of(w_nstate);
      r_wen   <= w_nwen;
      r_adv   <= w_nadv;
      r_clr   <= w_nclr;
    end
  end

  assign select    = r_sel;
  assign mode_leds = r_led;
  assign w_en      = r_wen;
  assign adv       = r_adv;
  assign clr_idx   = r_clr;
  assign len       = r_len;

endmodule

// File: tb/tb_simon_sequencer.sv
module tb_simon_sequencer;

  localparam int STEP = 4;
  localparam int TO   = 64;
  localparam int M_IN = 0, M_PB = 1, M_RP = 2, M_DN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic       is_legal = 1'b1;
  logic       input_match = 1'b1;
  logic       play_end, repeat_end;
  logic [1:0] select;
  logic [2:0] mode_leds;
  logic       w_en, adv, clr_idx;
  logic [6:0] len;

  int ncmp = 0;
  int nfail = 0;
  int hold_left = 0;

  // Environment: a minimal datapath index model driven by the DUT strobes.
  logic [6:0] play_idx, rep_idx;

  always #5 clk = ~clk;

  simon_sequencer #(.STEP_CYCLES(STEP), .MAX_LEN(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .step(step), .is_legal(is_legal),
    .play_end(play_end), .repeat_end(repeat_end), .input_match(input_match),
    .select(select), .mode_leds(mode_leds), .w_en(w_en), .adv(adv),
    .clr_idx(clr_idx), .len(len)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      play_idx <= '0;
      rep_idx  <= '0;
    end else if (clr_idx) begin
      play_idx <= '0;
      rep_idx  <= '0;
    end else if (adv) begin
      if (select == 2'b10) rep_idx  <= rep_idx + 7'd1;
      else                 play_idx <= play_idx + 7'd1;
    end
  end

  assign play_end   = (int'(play_idx) == int'(len) - 1);
  assign repeat_end = (int'(rep_idx) == int'(len) - 1);

  // Expected output vector {w_en, adv, clr_idx, select, mode_leds, len}.
  function automatic logic [14:0] ev(input int m, input logic w, input logic a,
                                     input logic c, input int l);
    logic [2:0] led;
    logic [1:0] sel;
    case (m)
      M_IN:    begin led = 3'b001; sel = 2'b00; end
      M_PB:    begin led = 3'b010; sel = 2'b01; end
      M_RP:    begin led = 3'b100; sel = 2'b10; end
      default: begin led = 3'b111; sel = 2'b11; end
    endcase
    return {w, a, c, sel, led, 7'(l)};
  endfunction

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {w_en, adv, clr_idx, select, mode_leds, len};
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input logic [14:0] exp);
    @(posedge clk);
    #1;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) step = 1'b0;
    end
    chk(tag, exp);
  endtask

  // Press with given hold; outputs must sit at idle for three cycles and
  // show exp4 on the fourth.
  task automatic press(input int h, input string tag, input logic [14:0] idle,
                       input logic [14:0] exp4);
    step = 1'b1;
    hold_left = h;
    repeat (3) tick({tag, "_wait"}, idle);
    tick(tag, exp4);
  endtask

  task automatic drain(input string tag, input logic [14:0] idle);
    while (hold_left > 0) tick(tag, idle);
    repeat (3) tick(tag, idle);
  endtask

  task automatic playback(input int r);
    for (int c = 1; c <= STEP * r; c++)
      tick("playback", ev((c == STEP * r) ? M_RP : M_PB, 1'b0,
                          (c % STEP == 0) && (c < STEP * r), c == STEP * r, r));
  endtask

  initial begin
    logic [14:0] idle;
    int mis_at;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset", ev(M_IN, 0, 0, 0, 0));
    rst = 1'b1;
    mis_at = $urandom_range(0, 3);

    for (int r = 1; r <= 4; r++) begin
      idle = ev(M_IN, 0, 0, 0, r - 1);
      drain("in_gap", idle);
      if ($urandom_range(0, 1) == 1) begin
        is_legal = 1'b0;
        press($urandom_range(1, 20), "illegal", idle, idle);
        drain("illegal_gap", idle);
        is_legal = 1'b1;
      end
      // First entry holds the button 20 cycles across playback and repeat.
      press((r == 1) ? 20 : $urandom_range(1, 20), "enter", idle, ev(M_PB, 1, 0, 1, r));
      playback(r);
      idle = ev(M_RP, 0, 0, 0, r);
      for (int i = 0; i < r; i++) begin
        drain("rep_gap", idle);
        if (r == 4 && i == mis_at) begin
          input_match = 1'b0;
          press($urandom_range(1, 6), "mismatch", idle, ev(M_DN, 0, 0, 1, r));
          break;
        end
        input_match = 1'b1;
        press($urandom_range(1, 6), "rep", idle,
              (i == r - 1) ? ev(M_IN, 0, 0, 1, r) : ev(M_RP, 0, 1, 0, r));
      end
    end

    // DONE loops over all four entries twice; a press midway is ignored.
    for (int c = 1; c <= 2 * 4 * STEP; c++) begin
      if (c == 12 && hold_left == 0) begin
        step = 1'b1;
        hold_left = 3;
      end
      tick("done", ev(M_DN, 0, (c % STEP == 0) && ((c / STEP) % 4 != 0),
                      (c % STEP == 0) && ((c / STEP) % 4 == 0), 4));
    end

    // Asynchronous reset from DONE, then again mid-playback.
    rst = 1'b0;
    #1 chk("rst_done", ev(M_IN, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b1;
    step = 1'b0;
    hold_left = 0;
    input_match = 1'b1;
    idle = ev(M_IN, 0, 0, 0, 0);
    drain("post_rst", idle);
    press(2, "enter2", idle, ev(M_PB, 1, 0, 1, 1));
    tick("pb2", ev(M_PB, 0, 0, 0, 1));
    tick("pb2", ev(M_PB, 0, 0, 0, 1));
    rst = 1'b0;
    #1 chk("rst_playback", ev(M_IN, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b1;
    tick("after_rst", ev(M_IN, 0, 0, 0, 0));
    tick("after_rst", ev(M_IN, 0, 0, 0, 0));

    // REPEAT with no presses at all.
    press(2, "enter3", idle, ev(M_PB, 1, 0, 1, 1));
    playback(1);
`ifdef SIMON_TIMEOUT_EN
    for (int c = 1; c <= TO; c++)
      tick("timeout", (c == TO) ? ev(M_DN, 0, 0, 1, 1) : ev(M_RP, 0, 0, 0, 1));
`else
    for (int c = 1; c <= TO + 16; c++)
      tick("rep_wait", ev(M_RP, 0, 0, 0, 1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
